// File: rtl/aes_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : aes_job_scheduler
// Brief    : Round-robin sequencer sharing one aes_core_rs among NREQ
//            requesters; optional WAIT watchdog enabled by AES_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_job_scheduler #(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*256-1:0] req_key,
    input  logic [NREQ*128-1:0] req_block,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [127:0]        rsp_data,
    output logic                rsp_err,
    output logic                core_rst_n,
    output logic                core_key_valid,
    output logic [7:0]          core_key_byte,
    input  logic                core_key_ready,
    output logic                core_st_valid,
    output logic [7:0]          core_st_byte,
    input  logic                core_st_ready,
    output logic                core_start,
    input  logic [127:0]        core_state_out,
    input  logic                core_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CRST  = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    localparam logic [5:0] C_KEY_BYTES = 6'd32;
    localparam logic [4:0] C_BLK_BYTES = 5'd16;

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_rr;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] w_gnt;
    logic           w_any;
    logic [255:0]   r_key;
    logic [255:0]   w_sel_key;
    logic [127:0]   r_blk;
    logic [127:0]   w_sel_blk;
    logic [127:0]   r_rsp_data;
    logic [5:0]     r_kc;
    logic [4:0]     r_sc;
    logic           r_core_rst_n;
    logic           w_in_load;
    logic           w_key_fire;
    logic           w_st_fire;
    logic           w_load_done;
    logic           w_timeout;
    int             w_dist;
    int             w_best;

    // Winner is the valid requester at the smallest distance after r_rr.
    always_comb begin
        w_any     = 1'b0;
        w_gnt     = '0;
        w_sel_key = '0;
        w_sel_blk = '0;
        w_dist    = 0;
        w_best    = NREQ + 1;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i > int'(r_rr)) ? (i - int'(r_rr)) : (i + NREQ - int'(r_rr));
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_any     = 1'b1;
                w_gnt     = IDW'(i);
                w_sel_key = req_key[256*i +: 256];
                w_sel_blk = req_block[128*i +: 128];
            end
        end
    end

    assign w_in_load      = (r_state == S_LOAD);
    assign core_key_valid = w_in_load && (r_kc < C_KEY_BYTES);
    assign core_st_valid  = w_in_load && (r_sc < C_BLK_BYTES);
    assign core_key_byte  = core_key_valid ? r_key[255:248] : 8'h00;
    assign core_st_byte   = core_st_valid  ? r_blk[127:120] : 8'h00;
    assign w_key_fire     = core_key_valid && core_key_ready;
    assign w_st_fire      = core_st_valid  && core_st_ready;

    // Look ahead one byte so LOAD lasts exactly 32 cycles when unstalled.
    assign w_load_done = ((r_kc == C_KEY_BYTES) || ((r_kc == C_KEY_BYTES - 6'd1) && w_key_fire)) &&
                         ((r_sc == C_BLK_BYTES) || ((r_sc == C_BLK_BYTES - 5'd1) && w_st_fire));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    for (int i = 0; i < NREQ; i++) begin
                        req_ready[i] = (w_gnt == IDW'(i));
                    end
                    w_next = S_CRST;
                end
            end
            S_CRST:  w_next = S_LOAD;
            S_LOAD:  if (w_load_done) w_next = S_START;
            S_START: begin
                core_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT:  if (core_done || w_timeout) w_next = S_RSP;
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr         <= IDW'(NREQ - 1);
            r_id         <= '0;
            r_key        <= '0;
            r_blk        <= '0;
            r_kc         <= '0;
            r_sc         <= '0;
            r_rsp_data   <= '0;
            r_core_rst_n <= 1'b0;
        end else begin
            // Registered so the core sees reset for exactly the CRST cycle.
            r_core_rst_n <= (w_next != S_CRST);
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_key <= w_sel_key;
                        r_blk <= w_sel_blk;
                        r_id  <= w_gnt;
                        r_rr  <= w_gnt;
                    end
                end
                S_CRST: begin
                    r_kc <= '0;
                    r_sc <= '0;
                end
                S_LOAD: begin
                    if (w_key_fire) begin
                        r_kc  <= r_kc + 6'd1;
                        r_key <= {r_key[247:0], 8'h00};
                    end
                    if (w_st_fire) begin
                        r_sc  <= r_sc + 5'd1;
                        r_blk <= {r_blk[119:0], 8'h00};
                    end
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_rsp_data <= core_state_out;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_rst_n = r_core_rst_n;
    assign rsp_id     = r_id;
    assign rsp_data   = r_rsp_data;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] r_to_cnt;
    logic           r_rsp_err;

    assign w_timeout = (r_state == S_WAIT) && !core_done &&
                       (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == S_START) begin
                r_to_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_state == S_WAIT) begin
                if (core_done) begin
                    r_rsp_err <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_err <= 1'b1;
                end
            end
        end
    end

    assign rsp_err = r_rsp_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign rsp_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_job_scheduler
// Brief    : Directed bench for aes_job_scheduler with a behavioural core stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_job_scheduler;

    localparam int NREQ = 2;
    localparam int LAT  = 3;

    localparam logic [255:0] FK = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [127:0] FP = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] FC = 128'h8ea2b7ca_516745bf_eafc4990_4b496089;
    localparam logic [255:0] K1 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    localparam logic [127:0] B1 = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
    localparam logic [255:0] K2 = 256'hc47b0294_dbbbee0f_ec4757f2_2ffeee35_87ca4730_c3d33b69_1df38bab_076bc558;
    localparam logic [255:0] K3 = 256'h01234567_89abcdef_fedcba98_76543210_00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] B2 = 128'hf69f2445_df4f9b17_ad2b417b_e66c3710;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*256-1:0] req_key;
    logic [NREQ*128-1:0] req_block;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [0:0]          rsp_id;
    logic [127:0]        rsp_data;
    logic                rsp_err;
    logic                core_rst_n;
    logic                core_key_valid;
    logic [7:0]          core_key_byte;
    logic                core_key_ready;
    logic                core_st_valid;
    logic [7:0]          core_st_byte;
    logic                core_st_ready;
    logic                core_start;
    logic [127:0]        core_state_out;
    logic                core_done;

    int n_tests = 0;
    int n_fail  = 0;

    aes_job_scheduler #(.NREQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_block(req_block),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_rst_n(core_rst_n),
        .core_key_valid(core_key_valid), .core_key_byte(core_key_byte), .core_key_ready(core_key_ready),
        .core_st_valid(core_st_valid), .core_st_byte(core_st_byte), .core_st_ready(core_st_ready),
        .core_start(core_start), .core_state_out(core_state_out), .core_done(core_done)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: the known AES-256 vector, otherwise a keyed mix.
    function automatic logic [127:0] model_ct(input logic [255:0] k, input logic [127:0] b);
        if (k == FK && b == FP) return FC;
        return k[255:128] ^ k[127:0] ^ {b[63:0], b[127:64]};
    endfunction

    // ---------------- core stub ----------------
    logic [5:0]   s_kc;
    logic [4:0]   s_sc;
    logic [255:0] cap_key;
    logic [127:0] cap_blk;
    logic         s_busy;
    logic         s_done;
    logic [127:0] s_out;
    int           s_lat;
    logic [31:0]  rnd;
    bit           stall_en  = 1'b0;
    bit           done_kill = 1'b0;
    int           low_run   = 0;
    int           last_low  = 0;
    int           stub_err  = 0;

    assign core_key_ready = (s_kc < 6'd32) && (!stall_en || (rnd[1:0] != 2'd0));
    assign core_st_ready  = (s_sc < 5'd16) && (!stall_en || (rnd[3:2] != 2'd0));
    assign core_done      = s_done;
    assign core_state_out = s_out;

    always @(posedge clk) begin
        rnd <= $urandom;
        if (!core_rst_n) begin
            s_kc   <= '0;
            s_sc   <= '0;
            s_busy <= 1'b0;
            s_done <= 1'b0;
            s_out  <= '0;
            s_lat  <= 0;
        end else begin
            s_done <= 1'b0;
            if (core_key_valid && core_key_ready) begin
                cap_key <= {cap_key[247:0], core_key_byte};
                s_kc    <= s_kc + 6'd1;
            end
            if (core_st_valid && core_st_ready) begin
                cap_blk <= {cap_blk[119:0], core_st_byte};
                s_sc    <= s_sc + 5'd1;
            end
            if (core_start) begin
                if (s_kc != 6'd32 || s_sc != 5'd16) stub_err <= stub_err + 1;
                s_busy <= 1'b1;
                s_lat  <= LAT;
            end else if (s_busy) begin
                if (s_lat == 1) begin
                    s_busy <= 1'b0;
                    s_done <= !done_kill;
                    s_out  <= model_ct(cap_key, cap_blk);
                end else begin
                    s_lat <= s_lat - 1;
                end
            end
        end
        if (!core_rst_n) begin
            low_run <= low_run + 1;
        end else if (low_run != 0) begin
            last_low <= low_run;
            low_run  <= 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int c = 0; c < 200; c++) begin
            #1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            if (g >= 0) break;
            @(posedge clk);
        end
    endtask

    task automatic run_job(input string tag, input int exp_g, input logic [127:0] exp_ct,
                           input bit drop, input int hold, output int lat);
        int           g;
        bit           got;
        bit           stable;
        bit           pulsed;
        logic [127:0] d0;
        logic [0:0]   id0;
        wait_grant(g);
        check({tag, "_grant"}, 256'(g), 256'(exp_g));
        got = 1'b0;
        lat = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            lat++;
            if (c == 0 && drop && g >= 0) req_valid[g] = 1'b0;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_rsp_valid"}, 256'(got), 256'(1));
        check({tag, "_rsp_id"}, 256'(rsp_id), 256'(exp_g));
        check({tag, "_rsp_data"}, 256'(rsp_data), 256'(exp_ct));
        check({tag, "_rsp_err"}, 256'(rsp_err), 256'(0));
        if (hold > 0) begin
            d0     = rsp_data;
            id0    = rsp_id;
            stable = 1'b1;
            pulsed = 1'b0;
            for (int c = 0; c < hold; c++) begin
                tick();
                if (!rsp_valid || rsp_data !== d0 || rsp_id !== id0) stable = 1'b0;
                if (|req_ready) pulsed = 1'b1;
            end
            check({tag, "_hold_stable"}, 256'(stable), 256'(1));
            check({tag, "_hold_no_grant"}, 256'(pulsed), 256'(0));
            rsp_ready = 1'b1;
        end
        tick();
        check({tag, "_rsp_released"}, 256'(rsp_valid), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int g;
        int n;
        bit seen;
        bit quiet;

        rst       = 1'b0;
        req_valid = '0;
        req_key   = '0;
        req_block = '0;
        rsp_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 256'(req_ready), 256'(0));
        check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        check("rst_core_rst_n", 256'(core_rst_n), 256'(0));
        check("rst_core_start", 256'(core_start), 256'(0));
        check("rst_key_valid", 256'(core_key_valid), 256'(0));
        check("rst_st_valid", 256'(core_st_valid), 256'(0));
        check("rst_rsp_data", 256'(rsp_data), 256'(0));
        check("rst_rsp_err", 256'(rsp_err), 256'(0));
        @(negedge clk) rst = 1'b0;
        tick();
        check("idle_core_rst_n", 256'(core_rst_n), 256'(1));

        // Known vector, no stalls; latency 1+32+1+(LAT+1)+1 from the grant cycle.
        req_key[255:0]   = FK;
        req_block[127:0] = FP;
        req_valid        = 2'b01;
        run_job("t1", 0, FC, 1'b1, 0, lat);
        check("t1_latency", 256'(lat), 256'(36 + LAT));
        check("t1_key_order", cap_key, FK);
        check("t1_blk_order", 256'(cap_blk), 256'(FP));
        check("t1_crst_len", 256'(last_low), 256'(1));

        // Random ready stalls on both load channels.
        stall_en  = 1'b1;
        req_valid = 2'b01;
        run_job("t3", 0, FC, 1'b1, 0, lat);
        check("t3_key_order", cap_key, FK);
        check("t3_blk_order", 256'(cap_blk), 256'(FP));
        stall_en = 1'b0;

        // Reset in the middle of a job: discarded, no response.
        req_key[511:256]   = K1;
        req_block[255:128] = B1;
        req_valid          = 2'b10;
        wait_grant(g);
        check("mid_grant", 256'(g), 256'(1));
        repeat (10) tick();
        @(negedge clk) rst = 1'b1;
        #1;
        check("mid_rst_core_rst_n", 256'(core_rst_n), 256'(0));
        check("mid_rst_key_valid", 256'(core_key_valid), 256'(0));
        req_valid = '0;
        @(negedge clk) rst = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (rsp_valid) quiet = 1'b0;
        end
        check("mid_no_rsp", 256'(quiet), 256'(1));

        // Both requesters continuously valid: alternate starting from 0.
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            run_job($sformatf("t2_job%0d", j), j % 2, (j % 2 == 0) ? FC : model_ct(K1, B1), 1'b0, 0, lat);
        end
        req_valid = '0;

        // Consumer back-pressure for 50 cycles with another request pending.
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        run_job("t4", 0, FC, 1'b0, 50, lat);
        req_valid = '0;

        // Back-to-back jobs from one requester with different keys.
        req_key[255:0]   = K2;
        req_block[127:0] = B2;
        req_valid        = 2'b01;
        run_job("t5a", 0, model_ct(K2, B2), 1'b0, 0, lat);
        req_key[255:0] = K3;
        check("t5a_crst_len", 256'(last_low), 256'(1));
        check("t5a_key_seen", cap_key, K2);
        run_job("t5b", 0, model_ct(K3, B2), 1'b1, 0, lat);
        check("t5b_crst_len", 256'(last_low), 256'(1));
        check("t5b_key_seen", cap_key, K3);

`ifdef AES_SCHED_TIMEOUT_EN
        // Core never completes: watchdog fires after 16 WAIT cycles.
        done_kill        = 1'b1;
        req_key[255:0]   = FK;
        req_block[127:0] = FP;
        req_valid        = 2'b01;
        wait_grant(g);
        check("t6_grant", 256'(g), 256'(0));
        tick();
        req_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (core_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t6_start_seen", 256'(seen), 256'(1));
        n = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            n++;
            if (rsp_valid) break;
        end
        check("t6_timeout_cycles", 256'(n), 256'(17));
        check("t6_rsp_err", 256'(rsp_err), 256'(1));
        check("t6_rsp_data", 256'(rsp_data), 256'(0));
        check("t6_rsp_id", 256'(rsp_id), 256'(0));
        tick();
        done_kill = 1'b0;
        req_valid = 2'b01;
        run_job("t6_recover", 0, FC, 1'b1, 0, lat);
`endif

        check("stub_protocol", 256'(stub_err), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
